// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C LIFO slave.
package i2c_pkg;

    localparam logic [6:0]  LIFO_ADDR = 7'b1111001;
    localparam int unsigned BYTE_W    = 8;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StWrData,
        StWrAck,
        StRdData,
        StRdAck,
        StWaitStop
    } state_e;

endpackage

// File: rtl/lifo_mem.sv
// Saturating LIFO storage; dout always shows the top entry.
module lifo_mem #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      count_q, count_d;
    logic [AW-1:0]    top_idx;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign top_idx = AW'(count_q - 1'b1);
    assign dout    = mem_q[top_idx];

    always_comb begin
        count_d = count_q;
        if (do_push) begin
            count_d = count_q + 1'b1;
        end else if (do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Contents survive reset; only the pointer is cleared.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[AW'(count_q)] <= din;
        end
    end

endmodule

// File: rtl/i2c_lifo_slave.sv
// I2C slave: written bytes are pushed onto a LIFO, reads pop them back (0xFF when empty).
module i2c_lifo_slave
    import i2c_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter logic [6:0]  SLV_ADDR = LIFO_ADDR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   scl,
    input  logic                   sda_in,
    output logic                   sda_oe,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    logic [1:0]        scl_sync_q, sda_sync_q;
    logic              scl_dly_q, sda_dly_q;
    logic              scl_s, sda_s;
    logic              scl_rise, scl_fall, start_det, stop_det;

    state_e            state_q, state_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic              rw_q, rw_d;
    logic              ack_q, ack_d;
    logic              sda_oe_q, sda_oe_d;
    logic              load_rd, push, pop;
    logic [BYTE_W-1:0] mem_dout, rd_byte;

    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign scl_rise  = scl_s & ~scl_dly_q;
    assign scl_fall  = ~scl_s & scl_dly_q;
    assign start_det = scl_s & scl_dly_q & sda_dly_q & ~sda_s;
    assign stop_det  = scl_s & scl_dly_q & ~sda_dly_q & sda_s;
    assign sda_oe    = sda_oe_q;
    assign rd_byte   = empty ? '1 : mem_dout;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_dly_q  <= 1'b1;
            sda_dly_q  <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl};
            sda_sync_q <= {sda_sync_q[0], sda_in};
            scl_dly_q  <= scl_sync_q[1];
            sda_dly_q  <= sda_sync_q[1];
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        rw_d      = rw_q;
        ack_d     = ack_q;
        sda_oe_d  = sda_oe_q;
        load_rd   = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;

        if (stop_det) begin
            state_d  = StIdle;
            sda_oe_d = 1'b0;
        end else if (start_det) begin
            state_d   = StAddr;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StWaitStop: ;
                StAddr: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[BYTE_W-2:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        rw_d = shift_q[0];
                        if (shift_q[BYTE_W-1:1] == SLV_ADDR) begin
                            state_d  = StAddrAck;
                            sda_oe_d = 1'b1;
                        end else begin
                            state_d  = StWaitStop;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                StAddrAck: begin
                    if (scl_fall) begin
                        bit_cnt_d = '0;
                        if (rw_q) begin
                            load_rd = 1'b1;
                        end else begin
                            state_d  = StWrData;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                StWrData: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[BYTE_W-2:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        state_d  = StWrAck;
                        push     = ~full;
                        sda_oe_d = ~full;
                    end
                end
                StWrAck: begin
                    if (scl_fall) begin
                        state_d   = StWrData;
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                    end
                end
                StRdData: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        state_d  = StRdAck;
                        sda_oe_d = 1'b0;
                    end else if (scl_fall && bit_cnt_q != 4'd0) begin
                        shift_d  = {shift_q[BYTE_W-2:0], 1'b0};
                        sda_oe_d = ~shift_q[BYTE_W-2];
                    end
                end
                StRdAck: begin
                    if (scl_rise) begin
                        ack_d = sda_s;
                    end else if (scl_fall) begin
                        if (!ack_q) begin
                            load_rd = 1'b1;
                        end else begin
                            state_d = StWaitStop;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase

            // Pop the top entry and put its MSB on the bus on the same falling edge.
            if (load_rd) begin
                state_d   = StRdData;
                bit_cnt_d = '0;
                pop       = ~empty;
                shift_d   = rd_byte;
                sda_oe_d  = ~rd_byte[BYTE_W-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            rw_q      <= 1'b0;
            ack_q     <= 1'b0;
            sda_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            rw_q      <= rw_d;
            ack_q     <= ack_d;
            sda_oe_q  <= sda_oe_d;
        end
    end

    lifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (BYTE_W)
    ) u_lifo_mem (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (shift_q),
        .dout  (mem_dout),
        .full  (full),
        .empty (empty),
        .count (count)
    );

endmodule

// File: tb/tb_i2c_lifo_slave.sv
// Bench for i2c_lifo_slave: bit-banged I2C master, LIFO model and read-data scoreboard.
module tb_i2c_lifo_slave;
    import i2c_pkg::*;

    localparam int unsigned DEPTH = 8;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   scl = 1'b1;
    logic                   sda_m = 1'b1;
    logic                   sda_in;
    logic                   sda_oe, full, empty;
    logic [$clog2(DEPTH):0] count;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] model[$];
    logic [7:0] exp_q[$];

    // Open-drain bus: either side can pull low.
    assign sda_in = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_lifo_slave #(
        .DEPTH    (DEPTH),
        .SLV_ADDR (7'b1111001)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .scl    (scl),
        .sda_in (sda_in),
        .sda_oe (sda_oe),
        .full   (full),
        .empty  (empty),
        .count  (count)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_q();
        repeat (10) @(posedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_q();
        scl = 1'b1;   wait_q();
        sda_m = 1'b0; wait_q();
        scl = 1'b0;   wait_q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_q();
        scl = 1'b1;   wait_q();
        sda_m = 1'b1; wait_q();
    endtask

    task automatic put_bit(input logic b);
        sda_m = b;  wait_q();
        scl = 1'b1; wait_q();
        scl = 1'b0; wait_q();
    endtask

    task automatic get_bit(output logic b);
        sda_m = 1'b1; wait_q();
        scl = 1'b1;   wait_q();
        @(negedge clk);
        b = sda_in;
        scl = 1'b0;   wait_q();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(ack);
    endtask

    task automatic addr_phase(input string tag, input logic [7:0] a, input logic exp_ack);
        logic ack;
        write_byte(a, ack);
        check_eq(tag, 32'(ack), 32'(exp_ack));
    endtask

    // Expected ACK comes from the model's occupancy, not the DUT flags.
    task automatic wr_data(input string tag, input logic [7:0] d);
        logic ack;
        logic exp_ack;
        exp_ack = (model.size() >= DEPTH);
        write_byte(d, ack);
        check_eq(tag, 32'(ack), 32'(exp_ack));
        if (!exp_ack) model.push_back(d);
    endtask

    task automatic rd_bytes(input string tag, input int n);
        logic [7:0] data;
        logic [7:0] exp;
        logic       b;
        for (int k = 0; k < n; k++) begin
            exp_q.push_back((model.size() != 0) ? model.pop_back() : 8'hFF);
            data = '0;
            for (int i = 7; i >= 0; i--) begin
                get_bit(b);
                data[i] = b;
            end
            put_bit(k == n - 1);
            if (exp_q.size() == 0) begin
                check_eq({tag, "_sb_empty"}, 32'(data), 32'hFFFF_FFFF);
            end else begin
                exp = exp_q.pop_front();
                check_eq(tag, 32'(data), 32'(exp));
            end
        end
    endtask

    task automatic check_occ(input string tag);
        @(negedge clk);
        check_eq({tag, "_count"}, 32'(count), 32'(model.size()));
        check_eq({tag, "_empty"}, 32'(empty), 32'(model.size() == 0));
        check_eq({tag, "_full"},  32'(full),  32'(model.size() == DEPTH));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic ack;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_eq("rst_sda_oe", 32'(sda_oe), 32'd0);
        check_eq("rst_state", 32'(dut.state_q), 32'(StIdle));
        rst = 1'b1;
        wait_q();
        check_occ("reset");

        // Two single-byte writes, then a two-byte read.
        i2c_start(); addr_phase("w1_addr", 8'hF2, 1'b0); wr_data("w1_ack", 8'h7A); i2c_stop();
        i2c_start(); addr_phase("w2_addr", 8'hF2, 1'b0); wr_data("w2_ack", 8'h5A); i2c_stop();
        check_occ("two_writes");
        i2c_start(); addr_phase("r1_addr", 8'hF3, 1'b0); rd_bytes("r1_data", 2); i2c_stop();
        check_occ("two_reads");

        // Foreign address is ignored until STOP.
        i2c_start();
        addr_phase("bad_addr_nack", 8'hE4, 1'b1);
        check_eq("bad_addr_state", 32'(dut.state_q), 32'(StWaitStop));
        write_byte(8'h55, ack);
        check_eq("bad_addr_data_nack", 32'(ack), 32'd1);
        i2c_stop();
        check_eq("bad_addr_stop_state", 32'(dut.state_q), 32'(StIdle));
        check_occ("bad_addr");

        // Overfill: ninth byte must be NACKed and dropped.
        i2c_start(); addr_phase("fill_addr", 8'hF2, 1'b0);
        for (int i = 1; i <= 9; i++) wr_data($sformatf("fill_ack%0d", i), 8'(i));
        i2c_stop();
        check_occ("filled");
        i2c_start(); addr_phase("fill_rd_addr", 8'hF3, 1'b0); rd_bytes("fill_rd_top", 1); i2c_stop();
        check_occ("after_top");
        i2c_start(); addr_phase("drain_addr", 8'hF3, 1'b0); rd_bytes("drain", 7); i2c_stop();
        check_occ("drained");

        // Empty read returns 0xFF.
        i2c_start(); addr_phase("empty_addr", 8'hF3, 1'b0); rd_bytes("empty_data", 1); i2c_stop();
        check_occ("empty_read");

        // Repeated START switches from write to read.
        i2c_start(); addr_phase("rs_waddr", 8'hF2, 1'b0); wr_data("rs_wack", 8'h11);
        i2c_start(); addr_phase("rs_raddr", 8'hF3, 1'b0); rd_bytes("rs_data", 1); i2c_stop();
        check_occ("rep_start");

        // Reset in the middle of a data byte.
        i2c_start(); addr_phase("pre_addr", 8'hF2, 1'b0); wr_data("pre_ack", 8'h77); i2c_stop();
        check_occ("pre_reset");
        i2c_start(); addr_phase("mid_addr", 8'hF2, 1'b0);
        put_bit(1'b0); put_bit(1'b0); put_bit(1'b1);
        sda_m = 1'b1; wait_q();
        scl = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("mid_rst_sda_oe", 32'(sda_oe), 32'd0);
        check_eq("mid_rst_state", 32'(dut.state_q), 32'(StIdle));
        check_eq("mid_rst_count", 32'(count), 32'd0);
        model.delete();
        wait_q();
        rst = 1'b1;
        wait_q();
        i2c_start(); addr_phase("post_addr", 8'hF2, 1'b0); wr_data("post_ack", 8'h3C); i2c_stop();
        check_occ("post_reset_write");
        i2c_start(); addr_phase("post_raddr", 8'hF3, 1'b0); rd_bytes("post_data", 1); i2c_stop();
        check_occ("post_reset_read");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/i2c_lifo_slave.md
I2C_LIFO_SLAVE -- requirements
Module: i2c_lifo_slave

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter DEPTH, default 8, SHALL set the number of LIFO entries (power of 2).
REQ-003 Parameter SLV_ADDR, default 7'b1111001, SHALL set the 7-bit slave address.
REQ-004 Port clk, input, 1: system clock; all logic on rising edge.
REQ-005 Port rst, input, 1: asynchronous active-low reset.
REQ-006 Port scl, input, 1: I2C clock from the master.
REQ-007 Port sda_in, input, 1: sampled SDA line.
REQ-008 Port sda_oe, output, 1: high means the slave pulls SDA low; the slave never drives high.
REQ-009 Port full, output, 1: the LIFO holds DEPTH entries.
REQ-010 Port empty, output, 1: the LIFO holds 0 entries.
REQ-011 Port count, output, $clog2(DEPTH)+1: current occupancy.

Function
REQ-012 scl and sda_in SHALL each pass through a 2-flop synchronizer, reset to 1, before any use; edges SHALL be detected against one further delayed copy.
REQ-013 START SHALL be detected when SDA falls while SCL is high; STOP when SDA rises while SCL is high. Both SHALL override any state.
REQ-014 States SHALL be: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
REQ-015 START SHALL go to ADDR from any state, which also covers repeated start. STOP SHALL go to IDLE and release sda_oe.
REQ-016 Bits SHALL be sampled on the SCL rising edge, MSB first. sda_oe SHALL change only on the SCL falling edge.
REQ-017 ADDR SHALL shift in 8 bits: a 7-bit address plus an R/W LSB, where 0 means write.
  - On match: drive ACK (sda_oe=1) for the 9th clock in ADDR_ACK.
  - On mismatch: go to WAIT_STOP with sda_oe=0.
REQ-018 After ADDR_ACK, on the falling edge, the slave SHALL go to WR_DATA if R/W=0, or RD_DATA if R/W=1.
REQ-019 In WR_DATA, after 8 bits, the byte SHALL be pushed on the 8th SCL falling edge if not full, and ACK driven in WR_ACK.
  - If full: NACK (sda_oe=0), no push, no change to contents.
REQ-020 After WR_ACK the slave SHALL return to WR_DATA for further bytes until STOP or START.
REQ-021 On entering RD_DATA, the top entry SHALL be popped (count-1) and loaded into the shift register.
  - Its bit 7 SHALL be presented on the same falling edge: sda_oe = ~bit.
REQ-022 If the LIFO is empty on entering RD_DATA, the byte sent SHALL be 8'hFF (sda_oe=0) and nothing is popped.
REQ-023 In RD_ACK the slave SHALL release SDA and sample the master's bit.
  - 0 (ACK): go to RD_DATA and pop the next entry.
  - 1 (NACK): go to WAIT_STOP.
REQ-024 full, empty and count SHALL update in the clk cycle after the push or pop strobe.
  - Push and pop SHALL never be asserted in the same cycle.
REQ-025 The stack pointer SHALL saturate: no increment when count=DEPTH, no decrement when count=0.

Reset
REQ-026 Reset SHALL force the following values:
  - state=IDLE, sda_oe=0, count=0, empty=1, full=0.
  - Synchronizer flops at 1, shift register and bit counter at 0.
REQ-027 Reset asserted mid-transaction SHALL abort immediately with no push or pop; storage contents need not be cleared.

Structure
REQ-028 Package i2c_pkg SHALL hold the state enum, the LIFO_ADDR constant (7'b1111001) and the byte width constant (8).
REQ-029 Storage SHALL be a sub-module lifo_mem with push, pop, din, dout, full, empty and count ports; the protocol FSM stays in i2c_lifo_slave.

Verification
REQ-030 Write 0x7A, then in a separate transaction write 0x5A, then read 2 bytes with ACK then NACK.
  - Expect 0x5A then 0x7A, with count going 2 -> 0.
REQ-031 Address byte 0xE4 (address 1110010, write) -> sda_oe stays 0 through the 9th clock, count unchanged, state WAIT_STOP until STOP.
REQ-032 Write 9 bytes 0x01..0x09 in one transaction.
  - Bytes 1-8 are ACKed; byte 9 is NACKed.
  - count=8, full=1, and the first read returns 0x08.
REQ-033 Read from empty (address byte 0xF3) -> ACK on the address, data 0xFF, count stays 0, empty=1.
REQ-034 Write 0x11, then repeated START with 0xF3 and read -> 0x11 returned, count 0.
REQ-035 Assert rst during the 4th data bit of a write -> sda_oe=0, state IDLE, count=0 within the reset assertion, and a subsequent write of 0x3C succeeds.
